// File: rtl/banco_pkg.sv
// Shared definitions for the board-state register bank: FSM encoding and width helpers.
package banco_pkg;

  typedef enum logic [0:0] {StIdle, StClear} banco_state_e;

  function automatic int unsigned addr_w(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_w(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/banco_registradores_if.sv
// Bus between game control (master) and the board-state bank (slave).
interface banco_registradores_if
  import banco_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 81
);
  localparam int unsigned ADDR_W = addr_w(DEPTH);
  localparam int unsigned CNT_W  = cnt_w(DEPTH);

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [N-1:0]      wdata;
  logic              wlock;
  logic [ADDR_W-1:0] raddr;
  logic [N-1:0]      rdata;
  logic              rlocked;
  logic              clr_start;
  logic              clr_all;
  logic              busy;
  logic              clr_done;
  logic              wr_rejected;
  logic [CNT_W-1:0]  nz_count;
  logic              undo;

  modport master (
    output we, waddr, wdata, wlock, raddr, clr_start, clr_all, undo,
    input  rdata, rlocked, busy, clr_done, wr_rejected, nz_count
  );

  modport slave (
    input  we, waddr, wdata, wlock, raddr, clr_start, clr_all, undo,
    output rdata, rlocked, busy, clr_done, wr_rejected, nz_count
  );

endinterface

// File: rtl/banco_celula.sv
// One bank entry: N-bit value plus lock bit. Clear beats write; set-lock beats clear-lock.
module banco_celula #(
  parameter int unsigned  N          = 4,
  parameter logic [N-1:0] INIT_VALUE = '0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         we,
  input  logic [N-1:0] wdata,
  input  logic         set_lock,
  input  logic         clr,
  input  logic         clr_lock,
  output logic [N-1:0] q,
  output logic         locked
);

  logic [N-1:0] val_q, val_d;
  logic         lock_q, lock_d;

  always_comb begin
    val_d  = val_q;
    lock_d = lock_q;
    if (clr) begin
      val_d = INIT_VALUE;
    end else if (we) begin
      val_d = wdata;
    end
    if (set_lock) begin
      lock_d = 1'b1;
    end else if (clr_lock) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      val_q  <= INIT_VALUE;
      lock_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      lock_q <= lock_d;
    end
  end

  assign q      = val_q;
  assign locked = lock_q;

endmodule

// File: rtl/banco_registradores.sv
// Board-state register bank with per-entry locks, clear sweep and nonzero counter.
// Optional one-deep write undo is built when BANCO_UNDO_EN is defined.
module banco_registradores
  import banco_pkg::*;
#(
  parameter int unsigned  N          = 4,
  parameter int unsigned  DEPTH      = 81,
  parameter logic [N-1:0] INIT_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rstn,
  banco_registradores_if.slave bus
);

  localparam int unsigned       ADDR_W  = addr_w(DEPTH);
  localparam int unsigned       CNT_W   = cnt_w(DEPTH);
  localparam logic [ADDR_W:0]   DepthA  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CntMax  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  NzReset = (INIT_VALUE != '0) ? CntMax : '0;

  logic [N-1:0]      val [DEPTH];
  logic [DEPTH-1:0]  lock;

  banco_state_e      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              clr_all_q, clr_all_d;
  logic              clr_done_q, clr_done_d;
  logic              wr_rej_q, wr_rej_d;
  logic [N-1:0]      rdata_q, rdata_d;
  logic              rlocked_q, rlocked_d;
  logic [CNT_W-1:0]  nz_q, nz_d;

  logic              idle, clearing, waddr_ok, raddr_ok, wr_ok, sweep_clr;
  logic              undo_ok;
  logic [ADDR_W-1:0] hist_addr;
  logic [N-1:0]      hist_val;
  logic              hist_lock;

  assign idle      = (state_q == StIdle);
  assign clearing  = (state_q == StClear);
  assign waddr_ok  = {1'b0, bus.waddr} < DepthA;
  assign raddr_ok  = {1'b0, bus.raddr} < DepthA;
  assign wr_ok     = idle && bus.we && waddr_ok && (!lock[bus.waddr] || bus.wlock);
  assign sweep_clr = clearing && (!lock[ptr_q] || clr_all_q);
  assign wr_rej_d  = bus.we && !wr_ok;

`ifdef BANCO_UNDO_EN
  logic              hist_valid_q;
  logic [ADDR_W-1:0] hist_addr_q;
  logic [N-1:0]      hist_val_q;
  logic              hist_lock_q;

  // A write in the same cycle always takes precedence over undo.
  assign undo_ok   = idle && bus.undo && !bus.we && hist_valid_q;
  assign hist_addr = hist_addr_q;
  assign hist_val  = hist_val_q;
  assign hist_lock = hist_lock_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist_valid_q <= 1'b0;
      hist_addr_q  <= '0;
      hist_val_q   <= '0;
      hist_lock_q  <= 1'b0;
    end else if (clearing) begin
      hist_valid_q <= 1'b0;
    end else if (wr_ok) begin
      hist_valid_q <= 1'b1;
      hist_addr_q  <= bus.waddr;
      hist_val_q   <= val[bus.waddr];
      hist_lock_q  <= lock[bus.waddr];
    end else if (undo_ok) begin
      hist_valid_q <= 1'b0;
    end
  end
`else
  logic unused_undo;
  assign unused_undo = bus.undo;
  assign undo_ok     = 1'b0;
  assign hist_addr   = '0;
  assign hist_val    = '0;
  assign hist_lock   = 1'b0;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic hit_w, hit_u, hit_c;
    assign hit_w = wr_ok && (bus.waddr == ADDR_W'(i));
    assign hit_u = undo_ok && (hist_addr == ADDR_W'(i));
    assign hit_c = clearing && (ptr_q == ADDR_W'(i));

    banco_celula #(
      .N          (N),
      .INIT_VALUE (INIT_VALUE)
    ) u_celula (
      .clk      (clk),
      .rstn     (rstn),
      .we       (hit_w || hit_u),
      .wdata    (hit_u ? hist_val : bus.wdata),
      .set_lock ((hit_w && bus.wlock) || (hit_u && hist_lock)),
      .clr      (hit_c && (!lock[i] || clr_all_q)),
      .clr_lock ((hit_c && clr_all_q) || (hit_u && !hist_lock)),
      .q        (val[i]),
      .locked   (lock[i])
    );
  end

  // At most one entry changes per cycle: write, undo and sweep are mutually exclusive.
  always_comb begin
    logic         chg;
    logic [N-1:0] ov, nv;
    chg  = 1'b0;
    ov   = '0;
    nv   = '0;
    nz_d = nz_q;
    if (wr_ok) begin
      chg = 1'b1;
      ov  = val[bus.waddr];
      nv  = bus.wdata;
    end else if (undo_ok) begin
      chg = 1'b1;
      ov  = val[hist_addr];
      nv  = hist_val;
    end else if (sweep_clr) begin
      chg = 1'b1;
      ov  = val[ptr_q];
      nv  = INIT_VALUE;
    end
    if (chg && (ov == '0) && (nv != '0) && (nz_q != CntMax)) begin
      nz_d = nz_q + 1'b1;
    end else if (chg && (ov != '0) && (nv == '0) && (nz_q != '0)) begin
      nz_d = nz_q - 1'b1;
    end
  end

  always_comb begin
    rdata_d   = '0;
    rlocked_d = 1'b0;
    if (raddr_ok) begin
      rdata_d   = val[bus.raddr];
      rlocked_d = lock[bus.raddr];
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    clr_all_d  = clr_all_q;
    clr_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.clr_start) begin
          state_d   = StClear;
          ptr_d     = '0;
          clr_all_d = bus.clr_all;
        end
      end
      StClear: begin
        if (ptr_q == LastPtr) begin
          state_d    = StIdle;
          clr_done_d = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      clr_all_q  <= 1'b0;
      clr_done_q <= 1'b0;
      wr_rej_q   <= 1'b0;
      rdata_q    <= '0;
      rlocked_q  <= 1'b0;
      nz_q       <= NzReset;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      clr_all_q  <= clr_all_d;
      clr_done_q <= clr_done_d;
      wr_rej_q   <= wr_rej_d;
      rdata_q    <= rdata_d;
      rlocked_q  <= rlocked_d;
      nz_q       <= nz_d;
    end
  end

  assign bus.rdata       = rdata_q;
  assign bus.rlocked     = rlocked_q;
  assign bus.busy        = clearing;
  assign bus.clr_done    = clr_done_q;
  assign bus.wr_rejected = wr_rej_q;
  assign bus.nz_count    = nz_q;

endmodule
